// File: rtl/edge_pulse_pkg.sv
// Shared edge-mode encoding and the per-channel edge qualifier.
package edge_pulse_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_t;

  // Qualify a current/previous sample pair against the selected edge mode.
  function automatic logic edge_hit(input logic cur, input logic prev, input edge_mode_t mode);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISE: hit = cur & ~prev;
      EDGE_FALL: hit = ~cur & prev;
      EDGE_BOTH: hit = cur ^ prev;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_pulse_channel.sv
// One channel: optional 2-flop synchroniser (EDGE_PULSE_SYNC_EN), edge detector,
// retriggerable pulse stretcher and sticky edge flag.
module edge_pulse_channel
  import edge_pulse_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       signal_in,
  input  edge_mode_t edge_mode,
  input  logic       flag_clr,
  output logic       pulse_out,
  output logic       event_flag,
  output logic       detect_c
);

  localparam int unsigned CNT_W = $clog2(PULSE_LEN + 1);

  logic             sample;
  logic             signal_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic             flag_next;

`ifdef EDGE_PULSE_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= signal_in;
      sync_q2 <= sync_q1;
    end
  end

  assign sample = sync_q2;
`else
  assign sample = signal_in;
`endif

  // A detection reloads the counter; otherwise it runs down and parks at zero.
  always_comb begin
    detect_c  = edge_hit(sample, signal_d, edge_mode);
    cnt_next  = cnt_q;
    flag_next = detect_c | (event_flag & ~flag_clr);
    if (detect_c) begin
      cnt_next = CNT_W'(PULSE_LEN);
    end else if (cnt_q != '0) begin
      cnt_next = cnt_q - CNT_W'(1);
    end
  end

  // pulse_out mirrors "counter non-zero" but comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      signal_d   <= 1'b0;
      cnt_q      <= '0;
      pulse_out  <= 1'b0;
      event_flag <= 1'b0;
    end else begin
      signal_d   <= sample;
      cnt_q      <= cnt_next;
      pulse_out  <= (cnt_next != '0);
      event_flag <= flag_next;
    end
  end

endmodule

// File: rtl/edge_pulse_detector.sv
// Multi-channel edge detector with stretched pulses and sticky flags.
// Define EDGE_PULSE_SYNC_EN to add a 2-flop input synchroniser per channel.
module edge_pulse_detector
  import edge_pulse_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned PULSE_LEN = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] signal_in,
  input  logic [1:0]       edge_mode,
  input  logic [WIDTH-1:0] flag_clr,
  output logic [WIDTH-1:0] pulse_out,
  output logic             any_pulse,
  output logic [WIDTH-1:0] event_flags
);

  edge_mode_t       mode;
  logic [WIDTH-1:0] detect;

  assign mode = edge_mode_t'(edge_mode);

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
    edge_pulse_channel #(
      .PULSE_LEN (PULSE_LEN)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .signal_in  (signal_in[i]),
      .edge_mode  (mode),
      .flag_clr   (flag_clr[i]),
      .pulse_out  (pulse_out[i]),
      .event_flag (event_flags[i]),
      .detect_c   (detect[i])
    );
  end

  // One-cycle strobe per cycle with any detection, regardless of pulse length.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      any_pulse <= 1'b0;
    end else begin
      any_pulse <= |detect;
    end
  end

endmodule

// File: doc/edge_pulse_detector.md
EDGE_PULSE_DETECTOR -- requirements
Module: edge_pulse_detector

Interface
REQ-001 Parameter WIDTH, default 4, number of independent input channels (1..32).
REQ-002 Parameter PULSE_LEN, default 1, output pulse length in clk cycles (1..255).
REQ-003 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 Port reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 Port signal_in  input  WIDTH  level inputs, one per channel.
REQ-006 Port edge_mode  input  2  global edge select: 00 rising, 01 falling, 10 both, 11 disabled.
REQ-007 Port flag_clr  input  WIDTH  per-channel clear strobe for sticky flags.
REQ-008 Port pulse_out  output  WIDTH  per-channel stretched pulse.
REQ-009 Port any_pulse  output  1  registered OR of all channel detections.
REQ-010 Port event_flags  output  WIDTH  per-channel sticky "edge seen" flags.

Function
REQ-011 Each channel SHALL hold a registered copy signal_d of its (optionally synchronised) input, updated every cycle.
REQ-012 Detection in cycle n SHALL be: rise = in & ~signal_d, fall = ~in & signal_d, qualified by edge_mode; mode 11 detects nothing.
REQ-013 A detection in cycle n SHALL load the channel down-counter with PULSE_LEN at edge n+1; pulse_out SHALL be high exactly while counter is non-zero (first high cycle n+1).
REQ-014 Counter width SHALL be $clog2(PULSE_LEN+1); counter decrements by 1 per cycle when non-zero, saturates at 0, never wraps.
REQ-015 Retrigger: detection while counter non-zero SHALL reload PULSE_LEN (pulse extended, no gap, no double count).
REQ-016 PULSE_LEN=1 SHALL yield single-cycle pulses; back-to-back edges on consecutive cycles (mode 10) SHALL give a continuous high.
REQ-017 any_pulse SHALL be high in cycle n+1 for exactly one cycle per cycle containing at least one detection on any channel, independent of PULSE_LEN.
REQ-018 event_flags[i] SHALL set on detection, clear on flag_clr[i]; simultaneous set and clear SHALL leave the flag set.
REQ-019 edge_mode change SHALL apply to detection from the cycle it is sampled; running pulses SHALL complete unaffected; mode 11 SHALL not clear counters or flags.
REQ-020 Channels SHALL be fully independent; no arbitration or priority between them.

Reset
REQ-021 While reset_n=0 at clk edge: signal_d, synchroniser flops, counters, pulse_out, any_pulse, event_flags all SHALL become 0.
REQ-022 An input held high across reset release SHALL count as a rising edge in the first cycle after release (signal_d resets to 0).
REQ-023 Reset asserted mid-pulse SHALL terminate the pulse at the next clk edge.

Configuration
REQ-024 Macro EDGE_PULSE_SYNC_EN defined: each signal_in bit SHALL pass a 2-flop synchroniser before detection, adding exactly 2 cycles latency (first pulse cycle n+3).
REQ-025 Macro undefined: signal_in SHALL feed detection directly; input assumed synchronous to clk.

Structure
REQ-026 Package edge_pulse_pkg SHALL hold edge_mode constants (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_OFF) and the 2-bit mode typedef.
REQ-027 One sub-module edge_pulse_channel (detector, counter, sticky flag, optional synchroniser) SHALL be instantiated WIDTH times via generate; top holds any_pulse OR-reduce.

Verification
REQ-028 WIDTH=4, PULSE_LEN=1, mode 00, signal_in[0] 0->1 at cycle 5 -> pulse_out[0] high cycle 6 only, any_pulse high cycle 6, event_flags[0]=1 from cycle 6.
REQ-029 PULSE_LEN=3, mode 01, signal_in[2] 1->0 at cycle 10, 1 again cycle 11, 0 again cycle 12 -> pulse_out[2] high cycles 11..15 continuously (retrigger at 13).
REQ-030 Mode 10, signal_in[1] toggling every cycle for 4 cycles -> pulse_out[1] high 4 consecutive cycles; mode 11 same stimulus -> pulse_out stays 0, flags unchanged.
REQ-031 flag_clr[3] and detection on channel 3 same cycle -> event_flags[3]=1; flag_clr[3] alone next cycle -> 0.
REQ-032 signal_in=4'hF held through reset, release at cycle 20, mode 00 -> pulse_out=4'hF cycle 21; reset_n=0 at cycle 22 with PULSE_LEN=5 -> all outputs 0 from cycle 23.
REQ-033 EDGE_PULSE_SYNC_EN defined, rising edge on channel 0 at cycle 5 -> pulse_out[0] first high cycle 8.
